// File: rtl/configs_loader.sv
// Configuration loader: accepts config words over a valid/ready stream and
// writes each one into an external bank of transparent latches. Every word
// passes through SETUP (data settles), STROBE (single one-hot enable) and
// HOLD (enable released, data still held) so the latches see a clean,
// glitch-free write.
module configs_loader #(
  parameter int NUM_WORDS = 23,
  parameter int WORD_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_start,
  input  logic                 io_abort,
  input  logic                 io_in_valid,
  input  logic [WORD_W-1:0]    io_in_data,
  output logic                 io_in_ready,
  output logic [WORD_W-1:0]    io_d_out,
  output logic [NUM_WORDS-1:0] io_configs_en,
  output logic                 io_busy,
  output logic                 io_done,
  output logic [4:0]           io_word_idx
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WORD_W-1:0]     r_d_out;
  logic [WORD_W-1:0]     w_d_out_next;
  logic [NUM_WORDS-1:0]  r_en;
  logic [NUM_WORDS-1:0]  w_en_next;
  logic [4:0]            r_word_idx;
  logic [4:0]            w_idx_next;
  logic [NUM_WORDS-1:0]  w_one;

  assign w_one = {{(NUM_WORDS-1){1'b0}}, 1'b1};

  // State register plus the flopped latch-bank drivers (data bus and enables).
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the data bus is reset too because it drives real latches
  // and must come up at a known value, unlike a plain pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_d_out    <= '0;
      r_en       <= '0;
      r_word_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_d_out    <= w_d_out_next;
      r_en       <= w_en_next;
      r_word_idx <= w_idx_next;
    end
  end

  // Next-state, next data bus, next index and next enable pattern.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_d_out_next = r_d_out;
    w_idx_next   = r_word_idx;

    if (io_abort) begin
      // Abort beats every other transition, including start while idle.
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_start) begin
            w_state_next = S_WAIT_DATA;
            w_idx_next   = '0;
          end
        end
        S_WAIT_DATA: begin
          if (io_in_valid) begin
            w_d_out_next = io_in_data;
            w_state_next = S_SETUP;
          end
        end
        S_SETUP:  w_state_next = S_STROBE;
        S_STROBE: w_state_next = S_HOLD;
        S_HOLD: begin
          if (r_word_idx == LAST_IDX) begin
            w_state_next = S_DONE;
          end else begin
            w_idx_next   = r_word_idx + 5'd1;
            w_state_next = S_WAIT_DATA;
          end
        end
        S_DONE:   w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end

    // Enable is computed one cycle ahead so the flop output is high exactly
    // while the FSM sits in STROBE; the index is stable from SETUP onwards.
    w_en_next = (w_state_next == S_STROBE) ? (w_one << r_word_idx) : '0;
  end

  assign io_d_out      = r_d_out;
  assign io_configs_en = r_en;
  assign io_word_idx   = r_word_idx;
  assign io_in_ready   = (r_state == S_WAIT_DATA);
  assign io_busy       = (r_state == S_WAIT_DATA) || (r_state == S_SETUP) ||
                         (r_state == S_STROBE)    || (r_state == S_HOLD);
  assign io_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_configs_loader.sv
// Directed bench for configs_loader: full load with an ignored start and a
// stalled word, abort mid-strobe with restart, async reset mid-strobe, and
// abort/start collision in idle. Per-cycle invariants run inside tick().
module tb_configs_loader;

  localparam int NW = 23;
  localparam int WW = 32;

  logic          clk;
  logic          reset;
  logic          io_start;
  logic          io_abort;
  logic          io_in_valid;
  logic [WW-1:0] io_in_data;
  logic          io_in_ready;
  logic [WW-1:0] io_d_out;
  logic [NW-1:0] io_configs_en;
  logic          io_busy;
  logic          io_done;
  logic [4:0]    io_word_idx;

  int n_vec;
  int n_err;
  int n_strobe;
  int n_done;
  int last_strobe_idx;
  logic          prev_locked;
  logic [WW-1:0] prev_dout;

  configs_loader #(.NUM_WORDS(NW), .WORD_W(WW)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_abort      (io_abort),
    .io_in_valid   (io_in_valid),
    .io_in_data    (io_in_data),
    .io_in_ready   (io_in_ready),
    .io_d_out      (io_d_out),
    .io_configs_en (io_configs_en),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_word_idx   (io_word_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge and run invariants.
  task automatic tick();
    logic locked;
    @(posedge clk);
    #1;
    check("onehot", 32'($countones(io_configs_en) <= 1), 32'd1);
    // busy && !ready identifies SETUP/STROBE/HOLD, where the bus must not move.
    locked = io_busy && !io_in_ready;
    if (locked && prev_locked) check("dout_stable", io_d_out, prev_dout);
    prev_locked = locked;
    prev_dout   = io_d_out;
    if (io_configs_en != '0) begin
      check("strobe_order", 32'(io_configs_en), 32'(1) << (last_strobe_idx + 1));
      last_strobe_idx++;
      n_strobe++;
    end
    if (io_done) n_done++;
  endtask

  task automatic reset_counts();
    n_strobe        = 0;
    n_done          = 0;
    last_strobe_idx = -1;
  endtask

  // One word in four cycles; valid stays high after the handshake with a
  // different value on the data bus, which must not be consumed.
  task automatic load_word(input int i, input logic [31:0] data, input bit pulse_start);
    check("wd_idx", 32'(io_word_idx), 32'(i));
    check("wd_ready", 32'(io_in_ready), 32'd1);
    io_in_valid = 1'b1;
    io_in_data  = data;
    tick();
    check("setup_dout", io_d_out, data);
    check("setup_en", 32'(io_configs_en), 32'd0);
    check("setup_ready", 32'(io_in_ready), 32'd0);
    io_in_data = ~data;
    if (pulse_start) io_start = 1'b1;
    tick();
    io_start = 1'b0;
    check("strobe_en", 32'(io_configs_en), 32'(1) << i);
    check("strobe_dout", io_d_out, data);
    tick();
    check("hold_en", 32'(io_configs_en), 32'd0);
    check("hold_dout", io_d_out, data);
    tick();
  endtask

  task automatic start_seq();
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    check("start_busy", 32'(io_busy), 32'd1);
    check("start_idx", 32'(io_word_idx), 32'd0);
    reset_counts();
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    prev_locked = 1'b0;
    prev_dout   = '0;
    reset_counts();
    io_start    = 1'b0;
    io_abort    = 1'b0;
    io_in_valid = 1'b0;
    io_in_data  = '0;
    reset       = 1'b1;

    // Reset state.
    #12;
    check("rst_en", 32'(io_configs_en), 32'd0);
    check("rst_dout", io_d_out, 32'd0);
    check("rst_idx", 32'(io_word_idx), 32'd0);
    check("rst_ready", 32'(io_in_ready), 32'd0);
    check("rst_busy", 32'(io_busy), 32'd0);
    check("rst_done", 32'(io_done), 32'd0);
    reset = 1'b0;

    // No sequence without start, even with data offered.
    io_in_valid = 1'b1;
    io_in_data  = 32'hCAFE_F00D;
    repeat (3) tick();
    check("nostart_ready", 32'(io_in_ready), 32'd0);
    check("nostart_busy", 32'(io_busy), 32'd0);
    check("nostart_dout", io_d_out, 32'd0);
    io_in_valid = 1'b0;

    // Full load: start ignored during word 3, 10-cycle stall before word 5.
    start_seq();
    for (int i = 0; i < NW; i++) begin
      if (i == 5) begin
        io_in_valid = 1'b0;
        repeat (10) begin
          tick();
          check("stall_ready", 32'(io_in_ready), 32'd1);
          check("stall_en", 32'(io_configs_en), 32'd0);
          check("stall_dout", io_d_out, 32'h1000_0004);
        end
      end
      load_word(i, 32'h1000_0000 + 32'(i), i == 3);
    end
    io_in_valid = 1'b0;
    check("done_pulse", 32'(io_done), 32'd1);
    check("done_busy", 32'(io_busy), 32'd0);
    check("done_idx", 32'(io_word_idx), 32'd22);
    tick();
    check("post_done", 32'(io_done), 32'd0);
    check("post_idx", 32'(io_word_idx), 32'd22);
    check("idle_dout", io_d_out, 32'h1000_0016);
    check("n_strobes", 32'(n_strobe), 32'd23);
    check("n_done", 32'(n_done), 32'd1);

    // Abort during STROBE of word 7, then restart from index 0.
    start_seq();
    for (int i = 0; i < 7; i++) load_word(i, 32'h2000_0000 + 32'(i), 1'b0);
    io_in_valid = 1'b1;
    io_in_data  = 32'h2000_0007;
    tick();
    tick();
    check("ab_strobe", 32'(io_configs_en), 32'h80);
    io_abort = 1'b1;
    tick();
    io_abort    = 1'b0;
    io_in_valid = 1'b0;
    check("ab_en", 32'(io_configs_en), 32'd0);
    check("ab_busy", 32'(io_busy), 32'd0);
    check("ab_ready", 32'(io_in_ready), 32'd0);
    check("ab_done", 32'(io_done), 32'd0);
    tick();
    check("ab_no_done", 32'(n_done), 32'd0);
    start_seq();
    load_word(0, 32'h3000_0000, 1'b0);
    load_word(1, 32'h3000_0001, 1'b0);

    // Async reset between edges while word 2 strobes.
    io_in_valid = 1'b1;
    io_in_data  = 32'h3000_0002;
    tick();
    tick();
    check("ar_strobe", 32'(io_configs_en), 32'h4);
    #2;
    reset = 1'b1;
    #1;
    check("ar_en", 32'(io_configs_en), 32'd0);
    check("ar_dout", io_d_out, 32'd0);
    check("ar_idx", 32'(io_word_idx), 32'd0);
    check("ar_busy", 32'(io_busy), 32'd0);
    #1;
    reset       = 1'b0;
    io_in_valid = 1'b0;
    tick();
    check("ar_idle", 32'(io_busy), 32'd0);

    // Abort and start together in IDLE: stay idle.
    io_start = 1'b1;
    io_abort = 1'b1;
    tick();
    io_start = 1'b0;
    io_abort = 1'b0;
    check("as_busy", 32'(io_busy), 32'd0);
    check("as_ready", 32'(io_in_ready), 32'd0);
    tick();
    check("as_still_idle", 32'(io_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
